// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the unified memory bus arbiter.
// Owner tags route in-order responses back to fetch or data.
package mem_bus_pkg;

  localparam int WADDR_W = 30;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_owner_fifo.sv
// In-order owner-tag FIFO, one bit wide, any depth >= 1.
// Pointers wrap explicitly so non-power-of-two depths work.
module owner_fifo #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          push_tag,
  input  logic          pop,
  output logic          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = mem_q[rd_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = push_tag;
      wr_d        = nxt(wr_q);
    end
    if (pop) begin
      rd_d = nxt(rd_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter onto one pipelined memory port.
// Data wins by default; a starvation counter forces fetch through.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic [3:0]  m_we,
  output logic [29:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        err
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_head;
  logic          full;
  logic          force_if;
  logic          if_win;
  logic          d_win;
  logic          push;
  logic          push_tag;
  logic          pop;
  logic [SW-1:0] starve_q, starve_d;
  logic          err_q, err_d;
  logic          d_addr_unused;

  assign d_addr_unused = ^d_addr[1:0];

  assign full     = (fifo_count == CW'(OUTSTANDING));
  assign force_if = (starve_q == SW'(STARVE_LIMIT));
  assign if_win   = if_req && (force_if || !d_req);
  assign d_win    = d_req && !if_win;

  // No bypass on full: m_req never depends on m_rvalid.
  assign m_req   = (if_req || d_req) && !full;
  assign m_addr  = if_win ? if_addr : d_addr[31:2];
  assign m_we    = d_win ? d_we : 4'b0000;
  assign m_wdata = d_wdata;

  assign if_gnt = if_win && m_req && m_gnt;
  assign d_gnt  = d_win && m_req && m_gnt;

  assign push     = (if_gnt || d_gnt) && !fifo_full;
  assign push_tag = d_gnt ? OWN_D : OWN_IF;
  assign pop      = m_rvalid && !fifo_empty;

  assign if_rvalid = pop && (fifo_head == OWN_IF);
  assign d_rvalid  = pop && (fifo_head == OWN_D);
  assign if_rdata  = m_rdata;
  assign d_rdata   = m_rdata;
  assign err       = err_q;

  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (!force_if) begin
      starve_d = starve_q + 1'b1;
    end
    err_d = err_q || (m_rvalid && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  owner_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (push_tag),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench with a response scoreboard for mem_bus_arbiter.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [29:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic [3:0]  m_we;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt, m_rvalid;
  logic [31:0] m_rdata;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        own;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .OUTSTANDING  (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_gnt     (m_gnt),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .err       (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic own, input logic [31:0] data);
    exp_t e;
    e.own  = own;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_rsp;
    exp_t e;
    chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("if_rvalid", 32'(if_rvalid), 32'(e.own == OWN_IF));
    chk("d_rvalid", 32'(d_rvalid), 32'(e.own == OWN_D));
    if (e.own == OWN_IF) chk("if_rdata", if_rdata, e.data);
    else chk("d_rdata", d_rdata, e.data);
  endtask

  task automatic check_idle;
    chk("idle_if_gnt", 32'(if_gnt), 32'd0);
    chk("idle_d_gnt", 32'(d_gnt), 32'd0);
    chk("idle_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("idle_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("idle_m_req", 32'(m_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    mid();
    check_idle();
    chk("reset_err", 32'(err), 32'd0);

    // fetch only
    tick();
    if_req = 1'b1; if_addr = 30'h10; m_gnt = 1'b1;
    mid();
    chk("t1_if_gnt", 32'(if_gnt), 32'd1);
    chk("t1_d_gnt", 32'(d_gnt), 32'd0);
    chk("t1_m_addr", 32'(m_addr), 32'h10);
    chk("t1_m_we", 32'(m_we), 32'd0);
    push_exp(OWN_IF, 32'hDEADBEEF);
    tick();
    if_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
    mid();
    check_rsp();
    tick();
    m_rvalid = 1'b0;

    // store and fetch together: data first
    if_req = 1'b1; if_addr = 30'h20;
    d_req = 1'b1; d_we = 4'b0011;
    d_addr = 32'h104; d_wdata = 32'h55AA;
    mid();
    chk("t2_d_gnt", 32'(d_gnt), 32'd1);
    chk("t2_if_gnt0", 32'(if_gnt), 32'd0);
    chk("t2_m_addr_d", 32'(m_addr), 32'h41);
    chk("t2_m_we_d", 32'(m_we), 32'h3);
    chk("t2_m_wdata", m_wdata, 32'h55AA);
    push_exp(OWN_D, 32'h0000ACED);
    tick();
    d_req = 1'b0; d_we = '0;
    mid();
    chk("t2_if_gnt1", 32'(if_gnt), 32'd1);
    chk("t2_m_addr_if", 32'(m_addr), 32'h20);
    chk("t2_m_we_if", 32'(m_we), 32'd0);
    push_exp(OWN_IF, 32'h12345678);
    tick();
    if_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000ACED;
    mid();
    check_rsp();
    tick();
    m_rdata = 32'h12345678;
    mid();
    check_rsp();
    tick();
    m_rvalid = 1'b0;

    // starvation: 4 data grants, then forced fetch
    for (int i = 0; i < 6; i++) begin
      if_req = (i < 5); if_addr = 30'h30;
      d_req = (i < 5); d_we = '0;
      d_addr = 32'h200 + 32'(4 * i);
      m_rvalid = (i > 0);
      m_rdata = 32'hA000_0000 + 32'(i - 1);
      mid();
      if (i > 0) check_rsp();
      if (i < 4) begin
        chk("t3_d_gnt", 32'(d_gnt), 32'd1);
        chk("t3_if_gnt", 32'(if_gnt), 32'd0);
        push_exp(OWN_D, 32'hA000_0000 + 32'(i));
      end else if (i == 4) begin
        chk("t3_force_if_gnt", 32'(if_gnt), 32'd1);
        chk("t3_force_d_gnt", 32'(d_gnt), 32'd0);
        push_exp(OWN_IF, 32'hA000_0000 + 32'(i));
      end else begin
        chk("t3_starve_clear", 32'(dut.starve_q), 32'd0);
      end
      tick();
    end
    m_rvalid = 1'b0;

    // full: two grants, stall, pop frees a slot next cycle
    d_req = 1'b1; d_addr = 32'h400;
    mid();
    chk("t4_gnt_a", 32'(d_gnt), 32'd1);
    push_exp(OWN_D, 32'hB0);
    tick();
    d_addr = 32'h404;
    mid();
    chk("t4_gnt_b", 32'(d_gnt), 32'd1);
    push_exp(OWN_D, 32'hB1);
    tick();
    d_addr = 32'h408;
    mid();
    chk("t4_full_m_req", 32'(m_req), 32'd0);
    chk("t4_full_d_gnt", 32'(d_gnt), 32'd0);
    tick();
    m_rvalid = 1'b1; m_rdata = 32'hB0;
    mid();
    chk("t4_pop_m_req", 32'(m_req), 32'd0);
    check_rsp();
    tick();
    m_rvalid = 1'b0;
    mid();
    chk("t4_after_m_req", 32'(m_req), 32'd1);
    chk("t4_after_d_gnt", 32'(d_gnt), 32'd1);
    push_exp(OWN_D, 32'hB2);
    tick();
    d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hB1;
    mid();
    check_rsp();
    tick();
    m_rdata = 32'hB2;
    mid();
    check_rsp();
    tick();

    // stray response sets sticky err
    m_rdata = 32'hBAD0;
    mid();
    chk("t5_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("t5_d_rvalid", 32'(d_rvalid), 32'd0);
    tick();
    m_rvalid = 1'b0;
    mid();
    chk("t5_err_set", 32'(err), 32'd1);
    tick();
    mid();
    chk("t5_err_sticky", 32'(err), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mid();
    chk("t5_err_clear", 32'(err), 32'd0);

    // reset with two in flight and a starving fetch
    tick();
    if_req = 1'b1; if_addr = 30'h50;
    d_req = 1'b1; d_addr = 32'h300;
    mid();
    chk("t6_gnt_a", 32'(d_gnt), 32'd1);
    tick();
    d_addr = 32'h304;
    mid();
    chk("t6_gnt_b", 32'(d_gnt), 32'd1);
    tick();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
    tick();
    rst = 1'b0;
    mid();
    chk("t6_fifo_cnt", 32'(dut.fifo_count), 32'd0);
    chk("t6_starve", 32'(dut.starve_q), 32'd0);
    check_idle();
    tick();
    if_req = 1'b1; if_addr = 30'h3C;
    mid();
    chk("t6_if_gnt", 32'(if_gnt), 32'd1);
    chk("t6_m_addr", 32'(m_addr), 32'h3C);
    push_exp(OWN_IF, 32'hCAFE_F00D);
    tick();
    if_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
    mid();
    check_rsp();
    tick();
    m_rvalid = 1'b0;
    mid();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
